// File: rtl/resq_pkg.sv
// Shared definitions for the relief-request dispatch scheduler.
// Holds the resource codes, the scheduler FSM states, the insert payload
// layout and a helper that maps a resource code to its queue-full flag.
package resq_pkg;

   localparam logic [1:0] RES_FOOD    = 2'b00;
   localparam logic [1:0] RES_SHELTER = 2'b01;
   localparam logic [1:0] RES_EVAC    = 2'b10;
   localparam logic [1:0] RES_INVALID = 2'b11;

   typedef enum logic [1:0] {
      DECIDE = 2'd0,
      INSERT = 2'd1,
      SERVE  = 2'd2
   } state_e;

   typedef struct packed {
      logic [7:0] zone;
      logic [1:0] prio;
      logic [1:0] res;
   } insert_req_t;

   // Full flag of the queue a resource code targets; invalid codes never block.
   function automatic logic target_full(input logic [1:0] res,
                                        input logic       food_full,
                                        input logic       shelter_full,
                                        input logic       evac_full);
      logic full;
      full = 1'b0;
      case (res)
         RES_FOOD:    full = food_full;
         RES_SHELTER: full = shelter_full;
         RES_EVAC:    full = evac_full;
         default:     full = 1'b0;
      endcase
      return full;
   endfunction

endpackage

// File: rtl/resq_team_timer.sv
// Per-team service timer: loads SERVICE_CYCLES on a dispatch and counts down;
// the team is busy while the count is nonzero.
// Ports: clk, rst_n (async active-low), load (dispatch to this team),
//        busy (registered busy flag).
module resq_team_timer #(
   parameter int unsigned SERVICE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic busy
);

   localparam int unsigned CNT_W = $clog2(SERVICE_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Load wins over countdown.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = CNT_W'(SERVICE_CYCLES);
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         busy    <= 1'b0;
      end else begin
         count_q <= count_d;
         busy    <= (count_d != '0);
      end
   end

endmodule

// File: rtl/resq_dispatch_scheduler.sv
// Front-end scheduler for the relief-request queue block.
// Arbitrates requesters onto the single Insert port (round-robin), issues
// Serve strobes when a dispatch team is free, and times each team's service.
// Every INSERT/SERVE cycle is followed by a DECIDE cycle so the queue block
// has one edge to update its flags before the next decision.
// Ports: Clock, Reset_n (async active-low); requester side Req_Valid/Zone/
//        Priority/Resource in, Req_Ready out (combinational grant); queue
//        status inputs; Insert/Zone/Priority/Resource_line and Serve/
//        Dispatch_Valid/Dispatch_Zone/Dispatch_Team outputs; Team_Busy.
// Optional: RESQ_SCHED_STATS_EN adds Dispatch_Count and Drop_Count.
module resq_dispatch_scheduler
   import resq_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned NUM_TEAMS      = 2,
   parameter int unsigned SERVICE_CYCLES = 8,
   parameter int unsigned TEAM_W         = (NUM_TEAMS > 1) ? $clog2(NUM_TEAMS) : 1
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic [NUM_REQ-1:0]     Req_Valid,
   input  logic [NUM_REQ*8-1:0]   Req_Zone,
   input  logic [NUM_REQ*2-1:0]   Req_Priority,
   input  logic [NUM_REQ*2-1:0]   Req_Resource,
   output logic [NUM_REQ-1:0]     Req_Ready,
   input  logic                   Shelter_Full,
   input  logic                   Food_Full,
   input  logic                   Evac_Full,
   input  logic                   Evac_Empty,
   input  logic                   Shelter_Valid,
   input  logic                   Food_Valid,
   input  logic [7:0]             Queue_Output_Zone,
   output logic                   Insert,
   output logic [7:0]             Zone,
   output logic [1:0]             Priority,
   output logic [1:0]             Resource_line,
   output logic                   Serve,
   output logic                   Dispatch_Valid,
   output logic [7:0]             Dispatch_Zone,
   output logic [TEAM_W-1:0]      Dispatch_Team,
   output logic [NUM_TEAMS-1:0]   Team_Busy
`ifdef RESQ_SCHED_STATS_EN
   ,
   output logic [15:0]            Dispatch_Count,
   output logic [7:0]             Drop_Count
`endif
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e               state_q;
   state_e               state_d;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     cand;
   logic [PTR_W-1:0]     ptr_next;
   logic                 last_serve_q;
   logic                 grant_found;
   logic                 do_insert;
   logic                 do_serve;
   logic                 drop;
   logic                 has_work;
   logic                 team_free;
   logic [NUM_REQ-1:0]   eligible;
   logic [TEAM_W-1:0]    free_team;
   insert_req_t          grant_req;
   logic [NUM_TEAMS-1:0] team_load;
   logic [NUM_TEAMS-1:0] team_busy;

   assign has_work  = ~Evac_Empty | Shelter_Valid | Food_Valid;
   assign Team_Busy = team_busy;

   // A requester is eligible when valid and its target queue can accept.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = Req_Valid[i] &
                       ~target_full(Req_Resource[2*i +: 2], Food_Full, Shelter_Full, Evac_Full);
      end
   end

   // Round-robin search starting at the pointer.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Payload of the winning requester.
   always_comb begin
      grant_req = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == PTR_W'(i)) begin
            grant_req.zone = Req_Zone[8*i +: 8];
            grant_req.prio = Req_Priority[2*i +: 2];
            grant_req.res  = Req_Resource[2*i +: 2];
         end
      end
   end

   assign ptr_next = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);

   // Lowest-index free team.
   always_comb begin
      team_free = 1'b0;
      free_team = '0;
      for (int t = int'(NUM_TEAMS) - 1; t >= 0; t--) begin
         if (!team_busy[t]) begin
            team_free = 1'b1;
            free_team = TEAM_W'(t);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= DECIDE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision; evac service first, then insert/serve alternation.
   always_comb begin
      state_d   = state_q;
      do_serve  = 1'b0;
      do_insert = 1'b0;
      case (state_q)
         DECIDE: begin
            if (!Evac_Empty && team_free) begin
               do_serve = 1'b1;
            end else if (grant_found && (last_serve_q || !has_work || !team_free)) begin
               do_insert = 1'b1;
            end else if (has_work && team_free) begin
               do_serve = 1'b1;
            end else if (grant_found) begin
               do_insert = 1'b1;
            end
            if (do_serve) begin
               state_d = SERVE;
            end else if (do_insert && (grant_req.res != RES_INVALID)) begin
               state_d = INSERT;
            end
         end
         default: state_d = DECIDE;
      endcase
   end

   // Invalid-resource grants are accepted and discarded without an Insert.
   assign drop = do_insert & (grant_req.res == RES_INVALID);

   always_comb begin
      Req_Ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         Req_Ready[i] = do_insert & (grant_idx == PTR_W'(i));
      end
   end

   // Registered strobes, payloads and arbitration history.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         rr_ptr_q       <= '0;
         last_serve_q   <= 1'b0;
         Insert         <= 1'b0;
         Serve          <= 1'b0;
         Dispatch_Valid <= 1'b0;
         Zone           <= '0;
         Priority       <= '0;
         Resource_line  <= '0;
         Dispatch_Zone  <= '0;
         Dispatch_Team  <= '0;
      end else begin
         Insert         <= (state_d == INSERT);
         Serve          <= (state_d == SERVE);
         Dispatch_Valid <= (state_d == SERVE);
         if (do_insert) begin
            rr_ptr_q     <= ptr_next;
            last_serve_q <= 1'b0;
            if (!drop) begin
               Zone          <= grant_req.zone;
               Priority      <= grant_req.prio;
               Resource_line <= grant_req.res;
            end
         end
         if (do_serve) begin
            last_serve_q  <= 1'b1;
            Dispatch_Zone <= Queue_Output_Zone;
            Dispatch_Team <= free_team;
         end
      end
   end

   // One service timer per team, loaded at the end of its SERVE cycle.
   for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
      assign team_load[t] = (state_q == SERVE) && (Dispatch_Team == TEAM_W'(t));
      resq_team_timer #(
         .SERVICE_CYCLES(SERVICE_CYCLES)
      ) u_timer (
         .clk  (Clock),
         .rst_n(Reset_n),
         .load (team_load[t]),
         .busy (team_busy[t])
      );
   end

`ifdef RESQ_SCHED_STATS_EN
   // Saturating activity counters.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Dispatch_Count <= '0;
         Drop_Count     <= '0;
      end else begin
         if ((state_q == SERVE) && (Dispatch_Count != 16'hFFFF)) begin
            Dispatch_Count <= Dispatch_Count + 16'd1;
         end
         if (drop && (Drop_Count != 8'hFF)) begin
            Drop_Count <= Drop_Count + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_resq_dispatch_scheduler.sv
// Self-checking bench for resq_dispatch_scheduler: directed scenarios with
// literal expectations followed by randomized traffic, all cross-checked
// every cycle against a transaction-level model of the scheduling rules.
module tb_resq_dispatch_scheduler;

   localparam int NR  = 4;
   localparam int NT  = 2;
   localparam int SVC = 8;

   logic         Clock;
   logic         Reset_n;
   logic [3:0]   Req_Valid;
   logic [31:0]  Req_Zone;
   logic [7:0]   Req_Priority;
   logic [7:0]   Req_Resource;
   logic [3:0]   Req_Ready;
   logic         Shelter_Full, Food_Full, Evac_Full, Evac_Empty;
   logic         Shelter_Valid, Food_Valid;
   logic [7:0]   Queue_Output_Zone;
   logic         Insert;
   logic [7:0]   Zone;
   logic [1:0]   Priority;
   logic [1:0]   Resource_line;
   logic         Serve;
   logic         Dispatch_Valid;
   logic [7:0]   Dispatch_Zone;
   logic [0:0]   Dispatch_Team;
   logic [1:0]   Team_Busy;
`ifdef RESQ_SCHED_STATS_EN
   logic [15:0]  Dispatch_Count;
   logic [7:0]   Drop_Count;
`endif

   resq_dispatch_scheduler dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .Req_Valid(Req_Valid), .Req_Zone(Req_Zone), .Req_Priority(Req_Priority),
      .Req_Resource(Req_Resource), .Req_Ready(Req_Ready),
      .Shelter_Full(Shelter_Full), .Food_Full(Food_Full), .Evac_Full(Evac_Full),
      .Evac_Empty(Evac_Empty), .Shelter_Valid(Shelter_Valid), .Food_Valid(Food_Valid),
      .Queue_Output_Zone(Queue_Output_Zone),
      .Insert(Insert), .Zone(Zone), .Priority(Priority), .Resource_line(Resource_line),
      .Serve(Serve), .Dispatch_Valid(Dispatch_Valid), .Dispatch_Zone(Dispatch_Zone),
      .Dispatch_Team(Dispatch_Team), .Team_Busy(Team_Busy)
`ifdef RESQ_SCHED_STATS_EN
      , .Dispatch_Count(Dispatch_Count), .Drop_Count(Drop_Count)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // Model: what the scheduler is doing this cycle (0 deciding, 1 insert, 2 serve)
   int         m_act;
   int         m_left [NT];
   int         m_rr;
   bit         m_last_serve;
   logic [7:0] m_zone;
   logic [1:0] m_pri, m_res;
   logic [7:0] m_dzone;
   int         m_dteam;
   int         m_disp_cnt, m_drop_cnt;

   int zone_log [$];
   int ins_cyc  [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_rr = 0; m_last_serve = 1'b0;
      m_zone = '0; m_pri = '0; m_res = '0; m_dzone = '0; m_dteam = 0;
      m_disp_cnt = 0; m_drop_cnt = 0;
      for (int t = 0; t < NT; t++) m_left[t] = 0;
   endtask

   function automatic bit m_full(input int idx);
      logic [1:0] r;
      r = Req_Resource[2*idx +: 2];
      if (r == 2'd0) return Food_Full;
      if (r == 2'd1) return Shelter_Full;
      if (r == 2'd2) return Evac_Full;
      return 1'b0;
   endfunction

   // Decision the scheduling rules call for in the current cycle.
   function automatic void m_decide(output int kind, output int g);
      bit free, work;
      int idx;
      free = 1'b0;
      for (int t = 0; t < NT; t++) if (m_left[t] == 0) free = 1'b1;
      work = !Evac_Empty || Shelter_Valid || Food_Valid;
      g = -1;
      for (int k = 0; k < NR; k++) begin
         idx = (m_rr + k) % NR;
         if (g < 0 && Req_Valid[idx] && !m_full(idx)) g = idx;
      end
      kind = 0;
      if (m_act != 0) return;
      if (!Evac_Empty && free)                          kind = 2;
      else if (g >= 0 && (m_last_serve || !work || !free)) kind = 1;
      else if (work && free)                            kind = 2;
      else if (g >= 0)                                  kind = 1;
   endfunction

   task automatic check_outputs();
      int kind, g;
      logic [3:0] er;
      logic [1:0] eb;
      m_decide(kind, g);
      er = '0;
      if (kind == 1) er = 4'(1 << g);
      eb = '0;
      for (int t = 0; t < NT; t++) eb[t] = (m_left[t] != 0);
      chk("ready",  32'(Req_Ready), 32'(er));
      chk("insert", 32'(Insert), 32'(m_act == 1));
      chk("serve",  32'(Serve), 32'(m_act == 2));
      chk("dvalid", 32'(Dispatch_Valid), 32'(m_act == 2));
      chk("busy",   32'(Team_Busy), 32'(eb));
      if (m_act == 1) begin
         chk("zone", 32'(Zone), 32'(m_zone));
         chk("prio", 32'(Priority), 32'(m_pri));
         chk("res",  32'(Resource_line), 32'(m_res));
      end
      if (m_act == 2) begin
         chk("dzone", 32'(Dispatch_Zone), 32'(m_dzone));
         chk("dteam", 32'(Dispatch_Team), 32'(m_dteam));
      end
`ifdef RESQ_SCHED_STATS_EN
      chk("disp_cnt", 32'(Dispatch_Count), 32'(m_disp_cnt));
      chk("drop_cnt", 32'(Drop_Count), 32'(m_drop_cnt));
`endif
      if (Insert) begin
         zone_log.push_back(int'(Zone));
         ins_cyc.push_back(cyc_n);
      end
   endtask

   task automatic model_edge();
      int kind, g, lowest;
      m_decide(kind, g);
      lowest = -1;
      for (int t = NT - 1; t >= 0; t--) if (m_left[t] == 0) lowest = t;
      for (int t = 0; t < NT; t++) begin
         if (m_act == 2 && t == m_dteam) m_left[t] = SVC;
         else if (m_left[t] > 0)         m_left[t]--;
      end
      if (m_act == 2 && m_disp_cnt < 65535) m_disp_cnt++;
      if (m_act != 0) begin
         m_act = 0;
      end else if (kind == 2) begin
         m_act = 2; m_last_serve = 1'b1;
         m_dzone = Queue_Output_Zone; m_dteam = lowest;
      end else if (kind == 1) begin
         m_rr = (g + 1) % NR; m_last_serve = 1'b0;
         if (Req_Resource[2*g +: 2] == 2'b11) begin
            if (m_drop_cnt < 255) m_drop_cnt++;
         end else begin
            m_act = 1;
            m_zone = Req_Zone[8*g +: 8];
            m_pri  = Req_Priority[2*g +: 2];
            m_res  = Req_Resource[2*g +: 2];
         end
      end
   endtask

   // One clock: check at the falling edge, advance the model, land just after the rise.
   task automatic cyc();
      @(negedge Clock);
      check_outputs();
      model_edge();
      @(posedge Clock);
      #1;
      cyc_n++;
   endtask

   task automatic idle_inputs();
      Req_Valid = '0; Shelter_Full = 0; Food_Full = 0; Evac_Full = 0;
      Evac_Empty = 1; Shelter_Valid = 0; Food_Valid = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int serve_cyc [$];
      int serve_team [$];
      int ins_busy;
      bit found;

      idle_inputs();
      Req_Zone = {8'h20, 8'h99, 8'h10, 8'h0C};
      Req_Priority = 8'b11_10_01_00;
      Req_Resource = 8'b01_01_01_01;
      Queue_Output_Zone = 8'h00;
      Reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge Clock);
      @(negedge Clock) Reset_n = 1'b1;
      @(posedge Clock); #1;

      // Reset state
      chk("rst_insert", 32'(Insert), 32'd0);
      chk("rst_serve",  32'(Serve), 32'd0);
      chk("rst_busy",   32'(Team_Busy), 32'd0);
      chk("rst_zone",   32'(Zone), 32'd0);
      chk("rst_dzone",  32'(Dispatch_Zone), 32'd0);
      chk("rst_ready",  32'(Req_Ready), 32'd0);
      repeat (2) cyc();

      // Round-robin over 1011, all shelter, no work
      Req_Valid = 4'b1011;
      zone_log.delete(); ins_cyc.delete();
      repeat (8) cyc();
      Req_Valid = '0;
      chk("rr_count", 32'(zone_log.size()), 32'd4);
      if (zone_log.size() == 4) begin
         chk("rr_zone0", 32'(zone_log[0]), 32'h0C);
         chk("rr_zone1", 32'(zone_log[1]), 32'h10);
         chk("rr_zone2", 32'(zone_log[2]), 32'h20);
         chk("rr_zone3", 32'(zone_log[3]), 32'h0C);
         for (int i = 0; i < 3; i++)
            chk("rr_spacing", 32'(ins_cyc[i+1] - ins_cyc[i]), 32'd2);
      end
      cyc();

      // Full blocking: req0 Food (full), req1 Shelter
      Req_Resource = 8'b01_01_01_00;
      Food_Full = 1; Req_Valid = 4'b0011;
      #1 chk("full_grant1", 32'(Req_Ready), 32'b0010);
      cyc();
      Req_Valid = 4'b0001;
      cyc();
      #1 chk("full_block", 32'(Req_Ready), 32'd0);
      cyc();
      Food_Full = 0;
      #1 chk("full_release", 32'(Req_Ready), 32'b0001);
      cyc();
      Req_Valid = '0;
      chk("full_ins_zone", 32'(Zone), 32'h0C);
      chk("full_ins_res",  32'(Resource_line), 32'd0);
      cyc();

      // Evac priority serve
      Evac_Empty = 0; Shelter_Valid = 1; Queue_Output_Zone = 8'h0C;
      cyc();
      chk("evac_serve", 32'(Serve), 32'd1);
      chk("evac_team",  32'(Dispatch_Team), 32'd0);
      chk("evac_zone",  32'(Dispatch_Zone), 32'h0C);
      Evac_Empty = 1; Shelter_Valid = 0;
      cyc();
      for (int i = 0; i < 8; i++) begin
         chk("evac_busy", 32'(Team_Busy), 32'b01);
         cyc();
      end
      chk("evac_free", 32'(Team_Busy), 32'b00);

      // Team exhaustion with a pending insert
      Req_Resource = 8'b01_01_01_01;
      Shelter_Valid = 1; Queue_Output_Zone = 8'h33;
      ins_busy = 0;
      for (int i = 0; i < 40 && serve_cyc.size() < 3; i++) begin
         if (Serve) begin
            serve_cyc.push_back(i);
            serve_team.push_back(int'(Dispatch_Team));
            if (serve_cyc.size() == 2) Req_Valid = 4'b0100;
         end
         if (Insert && Team_Busy == 2'b11) ins_busy++;
         cyc();
      end
      Shelter_Valid = 0; Req_Valid = '0;
      chk("exh_serves", 32'(serve_cyc.size()), 32'd3);
      if (serve_cyc.size() == 3) begin
         chk("exh_team0", 32'(serve_team[0]), 32'd0);
         chk("exh_team1", 32'(serve_team[1]), 32'd1);
         chk("exh_team2", 32'(serve_team[2]), 32'd0);
         chk("exh_gap",   32'(serve_cyc[2] - serve_cyc[0]), 32'd10);
         chk("exh_ins",   32'(ins_busy), 32'd3);
      end

      // Invalid resource drop
      Req_Resource = 8'b01_01_01_11; Req_Valid = 4'b0001;
      #1 chk("drop_ready", 32'(Req_Ready), 32'b0001);
      cyc();
      Req_Valid = '0;
      chk("drop_noins", 32'(Insert), 32'd0);
`ifdef RESQ_SCHED_STATS_EN
      chk("drop_count", 32'(Drop_Count), 32'd1);
`endif
      cyc();

      // Async reset during a SERVE cycle
      Req_Resource = 8'b01_01_01_01;
      Evac_Empty = 0; Queue_Output_Zone = 8'h55;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc();
         if (m_act == 2) found = 1'b1;
      end
      chk("rstmid_found", 32'(found), 32'd1);
      chk("rstmid_pre",   32'(Serve), 32'(found));
      #2 Reset_n = 1'b0;
      #1;
      chk("rstmid_serve", 32'(Serve), 32'd0);
      chk("rstmid_dval",  32'(Dispatch_Valid), 32'd0);
      chk("rstmid_busy",  32'(Team_Busy), 32'd0);
      model_reset();
      idle_inputs();
      @(negedge Clock) Reset_n = 1'b1;
      @(posedge Clock); #1;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_insert", 32'(Insert), 32'd0);
         chk("post_rst_serve",  32'(Serve), 32'd0);
         cyc();
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         Req_Valid     = 4'($urandom);
         Req_Zone      = $urandom;
         Req_Priority  = 8'($urandom);
         Req_Resource  = 8'($urandom);
         Food_Full     = ($urandom_range(3) == 0);
         Shelter_Full  = ($urandom_range(3) == 0);
         Evac_Full     = ($urandom_range(3) == 0);
         Evac_Empty    = ($urandom_range(4) != 0);
         Shelter_Valid = ($urandom_range(2) == 0);
         Food_Valid    = ($urandom_range(2) == 0);
         Queue_Output_Zone = 8'($urandom);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
